// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and the conditioned strobes/levels that feed the up/down counter.
interface button_conditioner_if;
  logic step_raw;
  logic dir_raw;
  logic clr_raw;
  logic step_pulse;
  logic dir;
  logic clr_pulse;
  logic step_held;

  modport master (
    output step_raw, dir_raw, clr_raw,
    input  step_pulse, dir, clr_pulse, step_held
  );

  modport slave (
    input  step_raw, dir_raw, clr_raw,
    output step_pulse, dir, clr_pulse, step_held
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronize, debounce and edge-detect three buttons; step channel auto-repeats while held.
module button_conditioner #(
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);
  localparam int NUM_CH  = 3;
  localparam int CH_STEP = 0;
  localparam int CH_DIR  = 1;
  localparam int CH_CLR  = 2;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REPEAT} state_t;

  logic [NUM_CH-1:0]            raw, s1, s2, db, db_q, rise;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             fire;
  logic             step_pulse_q, dir_q, clr_pulse_q;

  assign raw  = {bus.clr_raw, bus.dir_raw, bus.step_raw};
  assign rise = db & ~db_q;

  // Any sample of s2 matching db restarts the stability count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(STABLE_CYCLES - 1)) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    fire    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise[CH_STEP]) begin
          fire    = 1'b1;
          t_d     = '0;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (!db[CH_STEP]) begin
          t_d     = '0;
          state_d = S_IDLE;
        end else if (t_q == CNT_W'(HOLD_CYCLES - 1)) begin
          fire    = 1'b1;
          t_d     = '0;
          state_d = S_REPEAT;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!db[CH_STEP]) begin
          t_d     = '0;
          state_d = S_IDLE;
        end else if (t_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          fire = 1'b1;
          t_d  = '0;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      default: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A clear strobe suppresses a coincident step strobe; the FSM still advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      step_pulse_q <= 1'b0;
      dir_q        <= 1'b0;
      clr_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      step_pulse_q <= fire & ~rise[CH_CLR];
      dir_q        <= dir_q ^ rise[CH_DIR];
      clr_pulse_q  <= rise[CH_CLR];
    end
  end

  assign bus.step_pulse = step_pulse_q;
  assign bus.dir        = dir_q;
  assign bus.clr_pulse  = clr_pulse_q;
  assign bus.step_held  = (state_q == S_REPEAT);
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with STABLE=4, HOLD=8, REPEAT=3.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  button_conditioner_if bus();

  button_conditioner #(
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(3),
    .CNT_W        (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    bit          bounce;
    logic [63:0] pulse_mask;
    int          held_from;
    int          held_to;
  } press_vec_t;

  press_vec_t vecs [5];

  task automatic chk(input string name, input int e, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s edge %0d: got %b expected %b", name, e, act, exp);
  endtask

  task automatic chk_all(input string tag, input int e,
                         input logic sp, input logic d, input logic cp, input logic sh);
    chk({tag, ".step_pulse"}, e, bus.step_pulse, sp);
    chk({tag, ".dir"},        e, bus.dir,        d);
    chk({tag, ".clr_pulse"},  e, bus.clr_pulse,  cp);
    chk({tag, ".step_held"},  e, bus.step_held,  sh);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all("reset", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{6,  1'b0, 64'd1 << 7, 99, 0};
    vecs[1] = '{12, 1'b1, 64'd0,      99, 0};
    vecs[2] = '{8,  1'b0, 64'd1 << 7, 99, 0};
    vecs[3] = '{10, 1'b0, (64'd1 << 7) | (64'd1 << 15), 15, 16};
    vecs[4] = '{28, 1'b0, (64'd1 << 7)  | (64'd1 << 15) | (64'd1 << 18) | (64'd1 << 21) |
                          (64'd1 << 24) | (64'd1 << 27) | (64'd1 << 30) | (64'd1 << 33), 15, 34};

    // Reset with all buttons pressed, then release: clear wins over step at edge 7.
    rst_n = 1'b0;
    bus.step_raw = 1'b1;
    bus.dir_raw  = 1'b1;
    bus.clr_raw  = 1'b1;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      chk_all("rst_release", e, 1'b0, e >= 7, e == 7, 1'b0);
    end
    bus.step_raw = 1'b0;
    bus.dir_raw  = 1'b0;
    bus.clr_raw  = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_reset();

    // Step press table: clean, bounce, seen-low boundary, single repeat, long hold.
    for (int v = 0; v < 5; v++) begin
      for (int e = 0; e < 42; e++) begin
        @(posedge clk); #1;
        if (e > 0) begin
          chk($sformatf("vec%0d.step_pulse", v), e, bus.step_pulse, vecs[v].pulse_mask[e]);
          chk($sformatf("vec%0d.step_held", v), e, bus.step_held,
              (e >= vecs[v].held_from) && (e <= vecs[v].held_to));
        end
        bus.step_raw = (e < vecs[v].len) && (!vecs[v].bounce || ((e / 2) % 2 == 0));
      end
    end

    // Two direction presses 20 cycles apart.
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e > 0) chk_all("dir", e, 1'b0, (e >= 7) && (e < 27), 1'b0, 1'b0);
      bus.dir_raw = (e <= 5) || (e >= 20 && e <= 25);
    end
    do_reset();

    // Clear priority, then reset while in REPEAT with step still held.
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e > 0) chk_all("clr_rst", e, (e == 15) || (e == 18) || (e == 28), 1'b0,
                         e == 7, (e >= 15) && (e <= 20));
      if (e == 0) begin
        bus.step_raw = 1'b1;
        bus.clr_raw  = 1'b1;
      end
      if (e == 6)  bus.clr_raw = 1'b0;
      if (e == 20) rst_n = 1'b0;
      if (e == 21) rst_n = 1'b1;
    end
    bus.step_raw = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage that sits directly upstream of the 4-bit up/down counter. It turns three raw, bouncing push-button inputs into clean single-cycle control strobes: a step strobe with auto-repeat while held, a toggled direction level, and a clear strobe. Its outputs drive the counter's count-enable, up/down select and clear.

## Interface
- `STABLE_CYCLES`, default 16: consecutive cycles a synchronized input must differ from its debounced state before the debounced state flips. Must be ≥2.
- `HOLD_CYCLES`, default 64: cycles from the first step strobe to the first auto-repeat strobe. Must be ≥2.
- `REPEAT_CYCLES`, default 16: cycles between auto-repeat strobes. Must be ≥2.
- `CNT_W`, default 16: width of the debounce and hold timers. Must be ≥ clog2(max(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)).
- `clk` in 1: the single clock; all flops use its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `step_raw` in 1: raw step button, active high, asynchronous to `clk`.
- `dir_raw` in 1: raw direction button, active high, asynchronous.
- `clr_raw` in 1: raw clear button, active high, asynchronous.
- `step_pulse` out 1: one-cycle step strobe (counter count-enable).
- `dir` out 1: direction level, 0 = up, 1 = down (counter select).
- `clr_pulse` out 1: one-cycle clear strobe.
- `step_held` out 1: high while the step FSM is in REPEAT.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer (s1 → s2).
- **Debouncer, one per channel:** holds a state `db` and a counter `cnt`.
  - If s2 == db: cnt ← 0.
  - Otherwise cnt increments. On the cycle cnt == STABLE_CYCLES−1 while the mismatch persists, db ← s2 and cnt ← 0.
- **Edge detect:** a rise of db is detected by comparing db with db_q (db delayed one cycle). All outputs are registered.
- **dir:** toggles on each rise of db_dir. Releases have no effect.
- **clr_pulse:** high for exactly one cycle per rise of db_clr.
- **Step FSM, states IDLE / PRESS / REPEAT, with timer `t`:**
  - IDLE: on a rise of db_step, emit step_pulse, set t ← 0, go to PRESS.
  - PRESS: if db_step == 0, go to IDLE. Else t++. When t == HOLD_CYCLES−1, emit step_pulse, set t ← 0, go to REPEAT.
  - REPEAT: if db_step == 0, go to IDLE. Else t++. When t == REPEAT_CYCLES−1, emit step_pulse and set t ← 0.
  - In the cycle db_step is seen low, no strobe is emitted, even if t hits its terminal value.
- **Priority:** step_pulse is forced to 0 in any cycle where clr_pulse is 1. The FSM and timer still advance normally.
- **Reset:** while rst_n == 0 at a clock edge, all synchronizer flops, db, db_q, counters and timers clear to 0 and the FSM goes to IDLE.
  - Output reset values: step_pulse=0, dir=0, clr_pulse=0, step_held=0.
  - Reset mid-hold returns to IDLE. If the button is still pressed after reset, a fresh debounce follows, then a new first strobe.

## Timing
- Edge 0 is the first edge at which a raw input is sampled at its new level.
  - s2 changes at edge 2.
  - db changes at edge 2+STABLE_CYCLES.
  - step_pulse / clr_pulse / dir change at edge 3+STABLE_CYCLES.
- Any return of s2 to db before the threshold clears cnt. Bounces shorter than STABLE_CYCLES never propagate.
- Auto-repeat strobes follow at +HOLD_CYCLES after the first strobe, then every +REPEAT_CYCLES.
- Strobes are exactly 1 cycle wide. Throughput is at most 1 strobe per REPEAT_CYCLES after the initial hold.
- Releases are delayed by the same 2+STABLE_CYCLES edges before db falls.

## Test plan
All scenarios use STABLE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- **Reset:** hold rst_n=0 for 2 edges with all raw inputs at 1 → step_pulse=0, dir=0, clr_pulse=0, step_held=0 throughout; after release, no strobe before edge 7 (measured from the first sampled edge).
- **Clean press:** step_raw=1 for edges 0–5, then 0 → exactly one step_pulse, high between edges 7 and 8; step_held stays 0.
- **Bounce rejection:** step_raw toggles every 2 cycles for 12 cycles, then stays 0 → no step_pulse, db_step stays 0.
- **Hold and auto-repeat:** step_raw=1 for edges 0–27, then 0 → step_pulse at edges 7, 15, 18, 21, 24, 27, 30, 33 (8 strobes); step_held=1 from edge 15 until db_step falls at edge 34; no strobe after that.
- **Direction toggle:** two clean 6-cycle dir_raw presses, 20 cycles apart → dir goes 0→1 at edge 7, then 1→0 at edge 27.
- **Clear priority and reset mid-hold:** raise clr_raw and step_raw on the same edge → at edge 7, clr_pulse=1 and step_pulse=0. Then, while in REPEAT, drive rst_n=0 for 1 edge → all outputs 0 at that edge and the FSM returns to IDLE; with step_raw still high, the next strobe appears 3+STABLE_CYCLES edges after reset releases.
